mem_stage_lsu: RTL and testbench

//  Memory-stage load/store unit: consumes the EXE2MEM register outputs and drives a ready/req data-memory port.

---
 rtl/mem_pkg.sv | 18 +
 rtl/mem_load_align.sv | 19 +
 rtl/mem_stage_lsu.sv | 120 ++++++++++++
 tb/tb_mem_stage_lsu.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the memory-stage load/store unit
package mem_pkg;
    localparam int WORD_LEN = 32;
    typedef enum logic {IDLE, WAIT} lsu_state_t;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    typedef struct packed {
        logic                we;
        logic [WORD_LEN-1:0] addr;
        logic [WORD_LEN-1:0] wdata;
        logic [3:0]          be;
        logic [2:0]          f3;
        logic [1:0]          off;
    } lsu_req_t;
endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: selects the addressed byte/half of a read word and extends it
module mem_load_align import mem_pkg::*; (
    input  logic [WORD_LEN-1:0] rdata,
    input  logic [1:0]          off,
    input  logic [2:0]          funct3,
    output logic [WORD_LEN-1:0] data
);
    logic [7:0]  b;
    logic [15:0] h;
    // pick the lane, then sign- or zero-extend by funct3
    always_comb begin
        b = rdata[{off, 3'b000} +: 8];
        h = off[1] ? rdata[31:16] : rdata[15:0];
        data = funct3 == F3_B  ? {{24{b[7]}}, b} :
               funct3 == F3_BU ? {24'h0, b} :
               funct3 == F3_H  ? {{16{h[15]}}, h} :
               funct3 == F3_HU ? {16'h0, h} : rdata;
    end
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-stage load/store unit with ready/req data port and timeout
module mem_stage_lsu import mem_pkg::*; #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic                clk,
    input  logic                Reset,
    input  logic                Reg_W_En,
    input  logic                Mem_R_En,
    input  logic                Mem_W_En,
    input  logic [1:0]          WBsel,
    input  logic [WORD_LEN-1:0] rd2,
    input  logic [WORD_LEN-1:0] PCplus4,
    input  logic [WORD_LEN-1:0] ALURes,
    input  logic [WORD_LEN-1:0] Instruction,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [WORD_LEN-1:0] dmem_addr,
    output logic [WORD_LEN-1:0] dmem_wdata,
    output logic [3:0]          dmem_be,
    input  logic                dmem_ready,
    input  logic [WORD_LEN-1:0] dmem_rdata,
    output logic                mem_stall,
    output logic                mem_err,
    output logic                Reg_W_En_OUT,
    output logic [1:0]          WBsel_OUT,
    output logic [WORD_LEN-1:0] MemData_OUT,
    output logic [WORD_LEN-1:0] ALURes_OUT,
    output logic [WORD_LEN-1:0] PCplus4_OUT,
    output logic [WORD_LEN-1:0] Instruction_OUT
);
    lsu_state_t          state, state_nx;
    logic [CNT_W-1:0]    cnt;
    lsu_req_t            lat, nreq, cur;
    logic [2:0]          f3;
    logic [1:0]          off;
    logic                acc, bad, req, done, err, stall;
    logic [WORD_LEN-1:0] ld;
    assign f3   = Instruction[14:12];
    assign off  = ALURes[1:0];
    assign acc  = Mem_R_En || Mem_W_En;
    assign bad  = (Mem_R_En && Mem_W_En) || (f3[1:0] == 2'b10 && off != 2'b00) || (f3[1:0] == 2'b01 && off[0]);
    assign nreq = '{we: Mem_W_En, addr: {ALURes[31:2], 2'b00},
                    wdata: f3[1:0] == 2'b00 ? {4{rd2[7:0]}} : f3[1:0] == 2'b01 ? {2{rd2[15:0]}} : rd2,
                    be: f3[1:0] == 2'b00 ? 4'b0001 << off : f3[1:0] == 2'b01 ? 4'b0011 << off : 4'hF,
                    f3: f3, off: off};
    // next state and port handshake: fresh access in IDLE, latched copy while waiting
    always_comb begin
        state_nx = state;
        cur      = nreq;
        req      = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        stall    = 1'b0;
        if (state == IDLE) begin
            if (acc && bad) begin
                err = 1'b1;
            end else if (acc) begin
                req = 1'b1;
                if (dmem_ready) begin
                    done = 1'b1;
                end else begin
                    stall    = 1'b1;
                    state_nx = WAIT;
                end
            end
        end else begin
            cur = lat;
            if (dmem_ready) begin
                req      = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                err      = 1'b1;
                state_nx = IDLE;
            end else begin
                req   = 1'b1;
                stall = 1'b1;
            end
        end
        if (Reset) begin
            req      = 1'b0;
            done     = 1'b0;
            err      = 1'b0;
            stall    = 1'b0;
            state_nx = IDLE;
        end
    end
    // state, wait counter and the request copy captured when memory is not ready
    always_ff @(posedge clk) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
            lat   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= state == WAIT ? cnt + 1'b1 : '0;
            lat   <= (state == IDLE && stall) ? nreq : lat;
        end
    end
    mem_load_align u_align (
        .rdata  (dmem_rdata),
        .off    (cur.off),
        .funct3 (cur.f3),
        .data   (ld)
    );
    assign dmem_req        = req;
    assign dmem_we         = req && cur.we;
    assign dmem_addr       = req ? cur.addr : '0;
    assign dmem_wdata      = req ? cur.wdata : '0;
    assign dmem_be         = req ? cur.be : '0;
    assign mem_stall       = stall;
    assign mem_err         = err;
    assign Reg_W_En_OUT    = !Reset && Reg_W_En && !stall && !err;
    assign WBsel_OUT       = Reset ? '0 : WBsel;
    assign MemData_OUT     = (done && !cur.we) ? ld : '0;
    assign ALURes_OUT      = Reset ? '0 : ALURes;
    assign PCplus4_OUT     = Reset ? '0 : PCplus4;
    assign Instruction_OUT = (Reset || stall) ? '0 : Instruction;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: scoreboard bench for the memory-stage load/store unit
module tb_mem_stage_lsu;
    logic        clk = 1'b0;
    logic        Reset, Reg_W_En, Mem_R_En, Mem_W_En, dmem_ready;
    logic [1:0]  WBsel;
    logic [31:0] rd2, PCplus4, ALURes, Instruction, dmem_rdata;
    logic        dmem_req, dmem_we, mem_stall, mem_err, Reg_W_En_OUT;
    logic [31:0] dmem_addr, dmem_wdata, MemData_OUT, ALURes_OUT, PCplus4_OUT, Instruction_OUT;
    logic [3:0]  dmem_be;
    logic [1:0]  WBsel_OUT;
    int          checks = 0;
    int          errors = 0;
    typedef struct packed {logic [31:0] addr; logic [31:0] wdata; logic [3:0] be;} st_t;
    logic [31:0] ldq[$];
    st_t         stq[$];
    mem_stage_lsu #(.TIMEOUT_CYCLES(4), .CNT_W(5)) dut (
        .clk(clk), .Reset(Reset), .Reg_W_En(Reg_W_En), .Mem_R_En(Mem_R_En), .Mem_W_En(Mem_W_En),
        .WBsel(WBsel), .rd2(rd2), .PCplus4(PCplus4), .ALURes(ALURes), .Instruction(Instruction),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
        .mem_err(mem_err), .Reg_W_En_OUT(Reg_W_En_OUT), .WBsel_OUT(WBsel_OUT), .MemData_OUT(MemData_OUT),
        .ALURes_OUT(ALURes_OUT), .PCplus4_OUT(PCplus4_OUT), .Instruction_OUT(Instruction_OUT)
    );
    always #5 clk = ~clk;
    function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> (int'(off) * 8));
        h = 16'(w >> (int'(off) * 8));
        case (f3)
            3'b000:  return 32'($signed(b));
            3'b100:  return {24'h0, b};
            3'b001:  return 32'($signed(h));
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic set_idle;
        Reg_W_En = 0; Mem_R_En = 0; Mem_W_En = 0; WBsel = 0; rd2 = 0; PCplus4 = 0;
        ALURes = 0; Instruction = 0; dmem_ready = 0; dmem_rdata = 0;
    endtask
    task automatic set_mem(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        Reg_W_En = rd; Mem_R_En = rd; Mem_W_En = wr; WBsel = rd ? 2'b01 : 2'b00;
        ALURes = a; rd2 = d; PCplus4 = a + 32'h1000;
        Instruction = {17'h0, f3, 5'h5, rd ? 7'b0000011 : 7'b0100011};
    endtask
    task automatic test_reset;
        Reset = 1;
        set_mem(1, 0, 3'b010, 32'h100, 32'h55);
        dmem_ready = 1; dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, mem_stall, mem_err, Reg_W_En_OUT, WBsel_OUT,
             MemData_OUT, ALURes_OUT, PCplus4_OUT, Instruction_OUT} !== '0) begin
            errors++; $display("FAIL reset_outputs req=%b stall=%b alu=%h instr=%h want all 0", dmem_req, mem_stall, ALURes_OUT, Instruction_OUT);
        end
        tick; Reset = 0; set_idle;
        @(negedge clk);
        checks++;
        if ({dmem_req, mem_stall, mem_err} !== 3'b000) begin
            errors++; $display("FAIL post_reset_idle got %b want 000", {dmem_req, mem_stall, mem_err});
        end
        tick;
    endtask
    task automatic test_lb_zero_wait;
        set_mem(1, 0, 3'b000, 32'h103, 0);
        dmem_rdata = 32'h80FF_0000; dmem_ready = 1;
        ldq.push_back(ld_model(3'b000, 2'd3, 32'h80FF_0000));
        @(negedge clk);
        checks++;
        if (mem_stall !== 1'b0 || dmem_addr !== 32'h100 || dmem_we !== 1'b0) begin
            errors++; $display("FAIL lb_port stall=%b addr=%h we=%b want 0/100/0", mem_stall, dmem_addr, dmem_we);
        end
        checks++;
        if (!(dmem_req && dmem_ready) || ldq.size() == 0) begin
            errors++; $display("FAIL lb_complete req=%b want 1", dmem_req);
        end else if (MemData_OUT !== ldq.pop_front() || MemData_OUT !== 32'hFFFF_FF80 || Reg_W_En_OUT !== 1'b1) begin
            errors++; $display("FAIL lb_data got %h regw=%b want ffffff80 regw=1", MemData_OUT, Reg_W_En_OUT);
        end
        tick; set_idle;
    endtask
    task automatic test_stores;
        logic [2:0]  f3 [5] = '{3'b001, 3'b000, 3'b000, 3'b010, 3'b001};
        logic [31:0] a  [5] = '{32'h22, 32'h41, 32'h43, 32'h80, 32'h10};
        logic [31:0] d  [5] = '{32'h1234_ABCD, 32'h1234_ABCD, 32'h0000_00EE, 32'hDEAD_BEEF, 32'h0000_5678};
        logic [3:0]  be [5] = '{4'b1100, 4'b0010, 4'b1000, 4'b1111, 4'b0011};
        logic [31:0] wd [5] = '{32'hABCD_ABCD, 32'hCDCD_CDCD, 32'hEEEE_EEEE, 32'hDEAD_BEEF, 32'h5678_5678};
        st_t e;
        for (int i = 0; i < 5; i++) begin
            set_mem(0, 1, f3[i], a[i], d[i]);
            dmem_ready = 1;
            stq.push_back('{addr: a[i] & 32'hFFFF_FFFC, wdata: wd[i], be: be[i]});
            @(negedge clk);
            checks++;
            if (!(dmem_req && dmem_we) || stq.size() == 0) begin
                errors++; $display("FAIL store_req[%0d] req=%b we=%b want 1 1", i, dmem_req, dmem_we);
            end else begin
                e = stq.pop_front();
                if ({dmem_addr, dmem_wdata, dmem_be} !== {e.addr, e.wdata, e.be} || mem_stall !== 1'b0 || MemData_OUT !== 0) begin
                    errors++; $display("FAIL store[%0d] addr=%h wdata=%h be=%b want %h %h %b", i, dmem_addr, dmem_wdata, dmem_be, e.addr, e.wdata, e.be);
                end
            end
            tick;
        end
        set_idle;
    endtask
    task automatic test_wait_lw;
        logic [31:0] rv = $urandom;
        int stalls = 0;
        bit done = 0;
        set_mem(1, 0, 3'b010, 32'h40, 0);
        ldq.push_back(ld_model(3'b010, 2'd0, rv));
        for (int c = 0; c < 10 && !done; c++) begin
            dmem_ready = (c == 3); dmem_rdata = rv;
            @(negedge clk);
            checks++;
            if (dmem_req && dmem_ready) begin
                done = 1;
                if (MemData_OUT !== ldq.pop_front() || Reg_W_En_OUT !== 1'b1 || mem_stall !== 1'b0) begin
                    errors++; $display("FAIL lw_wait_done data=%h regw=%b stall=%b want %h 1 0", MemData_OUT, Reg_W_En_OUT, mem_stall, rv);
                end
            end else begin
                if (mem_stall) stalls++;
                if (dmem_addr !== 32'h40 || Reg_W_En_OUT !== 1'b0 || Instruction_OUT !== 0 || MemData_OUT !== 0) begin
                    errors++; $display("FAIL lw_wait_cycle[%0d] addr=%h regw=%b instr=%h want 40 0 0", c, dmem_addr, Reg_W_En_OUT, Instruction_OUT);
                end
            end
            tick;
        end
        checks++;
        if (!done || stalls != 3) begin
            errors++; $display("FAIL lw_wait_stalls got %0d done=%0d want 3 1", stalls, done);
        end
        set_idle;
    endtask
    task automatic test_latched_store;
        set_mem(0, 1, 3'b010, 32'h84, 32'h0BAD_F00D);
        @(negedge clk);
        tick;
        ALURes = 32'h200; rd2 = 32'h0; dmem_ready = 1;
        @(negedge clk);
        checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be} !== {2'b11, 32'h84, 32'h0BAD_F00D, 4'hF}) begin
            errors++; $display("FAIL latched_store addr=%h wdata=%h be=%b want 84 0badf00d 1111", dmem_addr, dmem_wdata, dmem_be);
        end
        tick; set_idle;
    endtask
    task automatic test_timeout;
        int reqs = 0, errs = 0, regw = 0;
        bit seen = 0;
        set_mem(1, 0, 3'b010, 32'h60, 0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (dmem_req) reqs++;
            if (Reg_W_En_OUT) regw++;
            if (mem_err) begin
                errs++; seen = 1;
                checks++;
                if ({dmem_req, mem_stall} !== 2'b00) begin
                    errors++; $display("FAIL timeout_abort req=%b stall=%b want 0 0", dmem_req, mem_stall);
                end
            end
            tick;
            if (seen) set_idle;
        end
        checks++;
        if (reqs != 4 || errs != 1 || regw != 0) begin
            errors++; $display("FAIL timeout_counts req=%0d err=%0d regw=%0d want 4 1 0", reqs, errs, regw);
        end
    endtask
    task automatic test_illegal;
        logic [2:0]  f3 [6] = '{3'b010, 3'b001, 3'b101, 3'b001, 3'b010, 3'b010};
        logic [31:0] a  [6] = '{32'h102, 32'h101, 32'h103, 32'h21, 32'h22, 32'h100};
        logic        rd [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic        wr [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            set_mem(rd[i], wr[i], f3[i], a[i], 32'h1111_2222);
            dmem_ready = 1;
            @(negedge clk);
            checks++;
            if ({dmem_req, mem_err, mem_stall, Reg_W_En_OUT} !== 4'b0100) begin
                errors++; $display("FAIL illegal[%0d] req/err/stall/regw=%b want 0100", i, {dmem_req, mem_err, mem_stall, Reg_W_En_OUT});
            end
            tick; set_idle;
            @(negedge clk);
            checks++;
            if (mem_err !== 1'b0) begin
                errors++; $display("FAIL illegal_pulse[%0d] err=%b want 0", i, mem_err);
            end
            tick;
        end
    endtask
    task automatic test_reset_in_wait;
        set_mem(1, 0, 3'b010, 32'h70, 0);
        @(negedge clk);
        tick;
        @(negedge clk);
        tick;
        Reset = 1;
        @(negedge clk);
        checks++;
        if ({dmem_req, mem_stall, mem_err, Reg_W_En_OUT, MemData_OUT, ALURes_OUT, Instruction_OUT, dmem_addr} !== '0) begin
            errors++; $display("FAIL reset_in_wait req=%b stall=%b addr=%h want all 0", dmem_req, mem_stall, dmem_addr);
        end
        tick; Reset = 0;
        set_mem(1, 0, 3'b100, 32'h30, 0);
        dmem_rdata = 32'h0000_00FF; dmem_ready = 1;
        ldq.push_back(ld_model(3'b100, 2'd0, 32'h0000_00FF));
        @(negedge clk);
        checks++;
        if (mem_stall !== 1'b0 || dmem_addr !== 32'h30 || MemData_OUT !== ldq.pop_front() || MemData_OUT !== 32'h0000_00FF) begin
            errors++; $display("FAIL lbu_after_reset addr=%h data=%h stall=%b want 30 000000ff 0", dmem_addr, MemData_OUT, mem_stall);
        end
        tick; set_idle;
    endtask
    task automatic test_passthrough;
        for (int i = 0; i < 4; i++) begin
            Reg_W_En = 1'($urandom); Mem_R_En = 0; Mem_W_En = 0; WBsel = 2'($urandom);
            rd2 = $urandom; PCplus4 = $urandom; ALURes = $urandom; Instruction = $urandom;
            dmem_ready = i[0]; dmem_rdata = $urandom;
            @(negedge clk);
            checks++;
            if ({Reg_W_En_OUT, WBsel_OUT, ALURes_OUT, PCplus4_OUT, Instruction_OUT, MemData_OUT, dmem_req, mem_stall, mem_err}
                !== {Reg_W_En, WBsel, ALURes, PCplus4, Instruction, 32'h0, 3'b000}) begin
                errors++; $display("FAIL passthrough[%0d] alu=%h pc=%h instr=%h data=%h req=%b want %h %h %h 0 0", i,
                                   ALURes_OUT, PCplus4_OUT, Instruction_OUT, MemData_OUT, dmem_req, ALURes, PCplus4, Instruction);
            end
            tick;
        end
        set_idle;
    endtask
    task automatic test_back_to_back;
        logic [2:0]  f3s [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] rv;
        int          w;
        bit          done;
        for (int i = 0; i < 8; i++) begin
            f3  = f3s[$urandom_range(4)];
            off = f3[1] ? 2'd0 : f3[0] ? {1'($urandom), 1'b0} : 2'($urandom);
            rv  = $urandom;
            w   = $urandom_range(2);
            set_mem(1, 0, f3, {24'h0, 6'($urandom), off}, 0);
            dmem_rdata = rv;
            ldq.push_back(ld_model(f3, off, rv));
            done = 0;
            for (int c = 0; c < 10 && !done; c++) begin
                dmem_ready = (c == w);
                @(negedge clk);
                if (dmem_req && dmem_ready) begin
                    done = 1;
                    checks++;
                    if (MemData_OUT !== ldq.pop_front() || Reg_W_En_OUT !== 1'b1) begin
                        errors++; $display("FAIL b2b[%0d] f3=%0d off=%0d rdata=%h got %h regw=%b", i, f3, off, rv, MemData_OUT, Reg_W_En_OUT);
                    end
                end
                tick;
            end
            if (!done) begin
                checks++; errors++;
                $display("FAIL b2b_budget[%0d] no completion got 0 want 1", i);
            end
        end
        set_idle;
        checks++;
        if (ldq.size() != 0 || stq.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain left %0d want 0", ldq.size() + stq.size());
        end
    endtask
    initial begin
        Reset = 1;
        set_idle;
        repeat (2) tick;
        test_reset;
        test_lb_zero_wait;
        test_stores;
        test_wait_lw;
        test_latched_store;
        test_timeout;
        test_illegal;
        test_reset_in_wait;
        test_passthrough;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
